// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between spi_slave and the board registers: decodes opcode words,
// updates LED/inversion/vector registers and queues response words for transmit.
module spi_cmd_ctrl #(
    parameter int VEC_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_data_available,
    input  logic [31:0] rd_data,
    output logic        rd_ack,
    input  logic        wr_buffer_free,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [15:0] leds,
    output logic        busy,
    output logic        err_unknown,
    output logic        err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SEND,
        S_GAP,
        S_VEC_RX
    } state_t;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_INIT    = 8'h01;
    localparam logic [7:0] OP_WR_INV  = 8'h02;
    localparam logic [7:0] OP_RD_INV  = 8'h03;
    localparam logic [7:0] OP_WR_LEDS = 8'h04;
    localparam logic [7:0] OP_RD_LEDS = 8'h05;
    localparam logic [7:0] OP_WR_VEC  = 8'h06;
    localparam logic [7:0] OP_RD_VEC  = 8'h07;

    state_t      state, state_nxt;
    logic        avail_q;
    logic        pending;
    logic        rise;
    logic        clr_pending;
    logic [31:0] word_q;
    logic [7:0]  opcode;
    logic [15:0] inv_reg;
    logic [23:0] vec_mem [VEC_DEPTH];
    logic [1:0]  vec_ptr;
    logic [1:0]  send_cnt;

    assign rise   = rd_data_available & ~avail_q;
    assign opcode = word_q[31:24];
    assign busy   = (state != S_IDLE);
    // Combinational so the response leaves in the first cycle SEND sees a free buffer.
    assign wr_en  = (state == S_SEND) && wr_buffer_free && !reset;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        clr_pending = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    clr_pending = 1'b1;
                    state_nxt   = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_RD_INV, OP_RD_LEDS, OP_RD_VEC: state_nxt = S_SEND;
                    OP_WR_VEC:                        state_nxt = S_VEC_RX;
                    default:                          state_nxt = S_IDLE;
                endcase
            end
            S_SEND: begin
                if (wr_buffer_free) state_nxt = S_GAP;
            end
            S_GAP: begin
                state_nxt = (send_cnt != 2'd0) ? S_SEND : S_IDLE;
            end
            S_VEC_RX: begin
                if (pending) begin
                    clr_pending = 1'b1;
                    if (vec_ptr == 2'd3) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avail_q     <= 1'b0;
            pending     <= 1'b0;
            rd_ack      <= 1'b0;
            word_q      <= '0;
            wr_data     <= '0;
            leds        <= '0;
            inv_reg     <= '0;
            vec_ptr     <= '0;
            send_cnt    <= '0;
            err_unknown <= 1'b0;
            err_overrun <= 1'b0;
            for (int i = 0; i < VEC_DEPTH; i++) vec_mem[i] <= '0;
        end else begin
            avail_q <= rd_data_available;
            rd_ack  <= rise;
            // A word arriving while one is still pending is acknowledged but dropped.
            if (rise && !pending) begin
                word_q  <= rd_data;
                pending <= 1'b1;
            end else begin
                if (rise)        err_overrun <= 1'b1;
                if (clr_pending) pending     <= 1'b0;
            end

            case (state)
                S_EXEC: begin
                    case (opcode)
                        OP_NOP: ;
                        OP_INIT: begin
                            leds        <= '0;
                            inv_reg     <= '0;
                            err_unknown <= 1'b0;
                            err_overrun <= 1'b0;
                            for (int i = 0; i < VEC_DEPTH; i++) vec_mem[i] <= '0;
                        end
                        OP_WR_INV:  inv_reg <= ~word_q[15:0];
                        OP_RD_INV: begin
                            wr_data  <= {OP_RD_INV, 8'h00, inv_reg};
                            send_cnt <= 2'd0;
                        end
                        OP_WR_LEDS: leds <= word_q[15:0];
                        OP_RD_LEDS: begin
                            wr_data  <= {OP_RD_LEDS, 8'h00, leds};
                            send_cnt <= 2'd0;
                        end
                        OP_WR_VEC:  vec_ptr <= 2'd0;
                        OP_RD_VEC: begin
                            vec_ptr  <= 2'd0;
                            wr_data  <= {OP_RD_VEC, vec_mem[0]};
                            send_cnt <= 2'd3;
                        end
                        default:    err_unknown <= 1'b1;
                    endcase
                end
                S_VEC_RX: begin
                    if (pending) begin
                        vec_mem[vec_ptr] <= word_q[23:0];
                        vec_ptr          <= vec_ptr + 2'd1;
                    end
                end
                S_GAP: begin
                    if (send_cnt != 2'd0) begin
                        vec_ptr  <= vec_ptr + 2'd1;
                        wr_data  <= {OP_RD_VEC, vec_mem[vec_ptr + 2'd1]};
                        send_cnt <= send_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: a table of single-command vectors plus hand-written
// sequences for cycle timing, vector transfer with back-pressure, overrun and mid-burst reset.
module tb_spi_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_data_available;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic        wr_buffer_free;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [15:0] leds;
    logic        busy;
    logic        err_unknown;
    logic        err_overrun;

    spi_cmd_ctrl #(.VEC_DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .rd_data_available (rd_data_available),
        .rd_data           (rd_data),
        .rd_ack            (rd_ack),
        .wr_buffer_free    (wr_buffer_free),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .leds              (leds),
        .busy              (busy),
        .err_unknown       (err_unknown),
        .err_overrun       (err_overrun)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Pulse monitor: counts rd_ack / wr_en pulses, logs transmitted words, flags spacing violations.
    int          ack_cnt = 0;
    int          wr_cnt  = 0;
    int          viol    = 0;
    int          cyc     = 0;
    int          last_wr = -10;
    logic        prev_ack = 1'b0;
    logic [31:0] wr_log [$];

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (rd_ack) begin
                ack_cnt++;
                if (prev_ack) viol++;
            end
            if (wr_en) begin
                wr_cnt++;
                wr_log.push_back(wr_data);
                if (cyc - last_wr < 2) viol++;
                last_wr = cyc;
            end
        end
        prev_ack = rd_ack;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            checks_passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    // Raise rd_data_available for one cycle with the given word.
    task automatic issue(input logic [31:0] w);
        step();
        rd_data           = w;
        rd_data_available = 1'b1;
        step();
        rd_data_available = 1'b0;
    endtask

    typedef struct {
        logic [31:0] word;
        logic [15:0] exp_leds;
        int          exp_wr;
        logic [31:0] exp_data;
        logic        exp_unk;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int ack0, wr0, k;

        tbl[0]  = '{32'h0400_0005, 16'h0005, 0, 32'h0,         1'b0};
        tbl[1]  = '{32'h0500_0000, 16'h0005, 1, 32'h0500_0005, 1'b0};
        tbl[2]  = '{32'h0200_1234, 16'h0005, 0, 32'h0,         1'b0};
        tbl[3]  = '{32'h0300_0000, 16'h0005, 1, 32'h0300_EDCB, 1'b0};
        tbl[4]  = '{32'h0400_ABCD, 16'hABCD, 0, 32'h0,         1'b0};
        tbl[5]  = '{32'h05FF_FFFF, 16'hABCD, 1, 32'h0500_ABCD, 1'b0};
        tbl[6]  = '{32'h0900_0000, 16'hABCD, 0, 32'h0,         1'b1};
        tbl[7]  = '{32'h0000_0000, 16'hABCD, 0, 32'h0,         1'b1};
        tbl[8]  = '{32'h0100_0000, 16'h0000, 0, 32'h0,         1'b0};
        tbl[9]  = '{32'h0500_0000, 16'h0000, 1, 32'h0500_0000, 1'b0};
        tbl[10] = '{32'h0300_0000, 16'h0000, 1, 32'h0300_0000, 1'b0};

        reset             = 1'b1;
        rd_data_available = 1'b0;
        rd_data           = '0;
        wr_buffer_free    = 1'b1;
        wait_cyc(3);
        chk("reset_rd_ack",  {31'b0, rd_ack}, 32'h0);
        chk("reset_wr_en",   {31'b0, wr_en}, 32'h0);
        chk("reset_wr_data", wr_data, 32'h0);
        chk("reset_leds",    {16'h0, leds}, 32'h0);
        chk("reset_busy",    {31'b0, busy}, 32'h0);
        chk("reset_errs",    {30'b0, err_unknown, err_overrun}, 32'h0);
        reset = 1'b0;
        wait_cyc(2);

        // Cycle-exact WR_LEDS / RD_LEDS timing.
        step();
        rd_data = 32'h0400_0005; rd_data_available = 1'b1;
        step();
        rd_data_available = 1'b0;
        chk("t_ack_n1",  {31'b0, rd_ack}, 32'h1);
        chk("t_leds_n1", {16'h0, leds}, 32'h0);
        step();
        chk("t_ack_n2",  {31'b0, rd_ack}, 32'h0);
        chk("t_busy_n2", {31'b0, busy}, 32'h1);
        chk("t_leds_n2", {16'h0, leds}, 32'h0);
        step();
        chk("t_leds_n3", {16'h0, leds}, 32'h5);
        step();
        rd_data = 32'h0500_0000; rd_data_available = 1'b1;
        step();
        rd_data_available = 1'b0;
        step();
        chk("t_wr_n2",   {31'b0, wr_en}, 32'h0);
        step();
        chk("t_wr_n3",   {31'b0, wr_en}, 32'h1);
        chk("t_data_n3", wr_data, 32'h0500_0005);
        step();
        chk("t_wr_gap",  {31'b0, wr_en}, 32'h0);
        step();
        chk("t_idle",    {31'b0, busy}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            ack0 = ack_cnt; wr0 = wr_cnt;
            issue(tbl[i].word);
            wait_cyc(8);
            chk($sformatf("tbl%0d_ack", i), ack_cnt - ack0, 32'd1);
            chk($sformatf("tbl%0d_nwr", i), wr_cnt - wr0, tbl[i].exp_wr);
            if (tbl[i].exp_wr == 1 && wr_cnt - wr0 == 1)
                chk($sformatf("tbl%0d_data", i), wr_log[wr0], tbl[i].exp_data);
            chk($sformatf("tbl%0d_leds", i), {16'h0, leds}, {16'h0, tbl[i].exp_leds});
            chk($sformatf("tbl%0d_unk", i), {31'b0, err_unknown}, {31'b0, tbl[i].exp_unk});
            chk($sformatf("tbl%0d_busy", i), {31'b0, busy}, 32'h0);
        end

        // WR_VEC with four payloads (opcode byte ignored), then RD_VEC with a stall before word 2.
        issue(32'h0600_0000);
        wait_cyc(3);
        chk("wrvec_busy", {31'b0, busy}, 32'h1);
        issue(32'hAA11_1111); wait_cyc(3);
        issue(32'h0022_2222); wait_cyc(3);
        issue(32'h0533_3333); wait_cyc(3);
        chk("wrvec_busy3", {31'b0, busy}, 32'h1);
        issue(32'h0744_4444); wait_cyc(3);
        chk("wrvec_done", {31'b0, busy}, 32'h0);
        chk("wrvec_unk",  {31'b0, err_unknown}, 32'h0);

        wr0 = wr_cnt;
        issue(32'h0700_0000);
        k = 0;
        while (wr_cnt - wr0 < 1 && k < 30) begin step(); k++; end
        chk("rdvec_first_seen", {31'b0, (wr_cnt - wr0 == 1)}, 32'h1);
        wr_buffer_free = 1'b0;
        wait_cyc(5);
        chk("rdvec_stalled", wr_cnt - wr0, 32'd1);
        chk("rdvec_stall_busy", {31'b0, busy}, 32'h1);
        wr_buffer_free = 1'b1;
        k = 0;
        while (wr_cnt - wr0 < 4 && k < 50) begin step(); k++; end
        wait_cyc(6);
        chk("rdvec_count", wr_cnt - wr0, 32'd4);
        if (wr_cnt - wr0 >= 4) begin
            chk("rdvec_w0", wr_log[wr0],     32'h0711_1111);
            chk("rdvec_w1", wr_log[wr0 + 1], 32'h0722_2222);
            chk("rdvec_w2", wr_log[wr0 + 2], 32'h0733_3333);
            chk("rdvec_w3", wr_log[wr0 + 3], 32'h0744_4444);
        end
        chk("rdvec_busy", {31'b0, busy}, 32'h0);

        // INIT clears the vector.
        issue(32'h0100_0000);
        wait_cyc(4);
        wr0 = wr_cnt;
        issue(32'h0700_0000);
        wait_cyc(20);
        chk("init_vec_count", wr_cnt - wr0, 32'd4);
        if (wr_cnt - wr0 >= 4) begin
            chk("init_vec_w0", wr_log[wr0],     32'h0700_0000);
            chk("init_vec_w3", wr_log[wr0 + 3], 32'h0700_0000);
        end

        // Two words arrive while SEND is stalled.
        wr_buffer_free = 1'b0;
        ack0 = ack_cnt; wr0 = wr_cnt;
        issue(32'h0500_0000);
        wait_cyc(4);
        issue(32'h0400_0077);
        wait_cyc(2);
        issue(32'h0400_0099);
        wait_cyc(3);
        chk("ovr_acks",   ack_cnt - ack0, 32'd3);
        chk("ovr_flag",   {31'b0, err_overrun}, 32'h1);
        chk("ovr_nowr",   wr_cnt - wr0, 32'd0);
        chk("ovr_leds_hold", {16'h0, leds}, 32'h0);
        wr_buffer_free = 1'b1;
        wait_cyc(10);
        chk("ovr_wr",     wr_cnt - wr0, 32'd1);
        if (wr_cnt - wr0 == 1) chk("ovr_data", wr_log[wr0], 32'h0500_0000);
        chk("ovr_leds",   {16'h0, leds}, 32'h0077);
        chk("ovr_idle",   {31'b0, busy}, 32'h0);

        // Reset during RD_VEC after the second word.
        issue(32'h0900_0000);
        wait_cyc(4);
        wr0 = wr_cnt;
        issue(32'h0700_0000);
        k = 0;
        while (wr_cnt - wr0 < 2 && k < 30) begin step(); k++; end
        chk("rst_two_seen", wr_cnt - wr0, 32'd2);
        reset = 1'b1;
        step();
        chk("rst_wr_en",   {31'b0, wr_en}, 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_leds",    {16'h0, leds}, 32'h0);
        chk("rst_busy",    {31'b0, busy}, 32'h0);
        chk("rst_errs",    {30'b0, err_unknown, err_overrun}, 32'h0);
        chk("rst_rd_ack",  {31'b0, rd_ack}, 32'h0);
        reset = 1'b0;
        wait_cyc(10);
        chk("rst_no_more_wr", wr_cnt - wr0, 32'd2);

        chk("pulse_spacing", viol, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer between `spi_slave` and the board-level registers. Consumes 32-bit words from the SPI slave receive port, decodes an 8-bit opcode, updates the LED, inversion and 4-entry vector registers, and queues response words on the SPI slave transmit port. Replaces ad-hoc receive/echo logic in the top level; one instance per SPI slave.

## Interface
- `VEC_DEPTH`, 4: number of 24-bit vector entries (fixed at 4 for this protocol; `vec_ptr` is 2 bits).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rd_data_available`  in  1  spi_slave: received word valid (level).
- `rd_data`  in  32  spi_slave: received word; [31:24] opcode, [23:0] payload.
- `rd_ack`  out  1  one-cycle pulse: word consumed.
- `wr_buffer_free`  in  1  spi_slave: transmit buffer can take a word.
- `wr_en`  out  1  one-cycle pulse: `wr_data` valid.
- `wr_data`  out  32  response word.
- `leds`  out  16  LED register (top level uses [2:0], active-high here).
- `busy`  out  1  high in any state other than IDLE.
- `err_unknown`  out  1  sticky: unknown opcode received.
- `err_overrun`  out  1  sticky: new word arrived while one was already pending.

## Operation
- Edge detector: `avail_q` registers `rd_data_available`; rising edge (1 now, `avail_q`=0) latches `rd_data` into `word_q`, sets `pending`, drives `rd_ack`=1 next cycle. Runs in every state. Edge while `pending`=1: `word_q` unchanged, `rd_ack` still pulsed, `err_overrun` set.
- States: IDLE, EXEC, SEND, GAP, VEC_RX.
- IDLE: `pending`=1 -> clear `pending`, go EXEC.
- EXEC decodes `word_q[31:24]`:
  - 0x00 NOP: -> IDLE.
  - 0x01 INIT: `leds`, `inv_reg`, vector[0..3], `err_unknown`, `err_overrun` <= 0; -> IDLE.
  - 0x02 WR_INVERTED: `inv_reg` <= ~`word_q[15:0]`; -> IDLE.
  - 0x03 RD_INVERTED: queue {8'h03, 8'h00, `inv_reg`}; -> SEND, count 1.
  - 0x04 WR_LEDS: `leds` <= `word_q[15:0]`; -> IDLE.
  - 0x05 RD_LEDS: queue {8'h05, 8'h00, `leds`}; -> SEND, count 1.
  - 0x06 WR_VEC: `vec_ptr` <= 0; -> VEC_RX.
  - 0x07 RD_VEC: `vec_ptr` <= 0; queue {8'h07, vector[0]}; -> SEND, count 4.
  - other: set `err_unknown`; -> IDLE.
- VEC_RX: each `pending` word: vector[`vec_ptr`] <= `word_q[23:0]` (opcode byte ignored), clear `pending`, `vec_ptr`++; after entry 3 -> IDLE. No timeout; INIT is not decoded inside VEC_RX.
- SEND: wait `wr_buffer_free`=1; pulse `wr_en` one cycle with queued word; -> GAP.
- GAP: one idle cycle (lets `wr_buffer_free` deassert). RD_VEC with words remaining: `vec_ptr`++, queue {8'h07, vector[`vec_ptr`+1]}, -> SEND; else -> IDLE.
- Words arriving during SEND/GAP set `pending` and are handled on return to IDLE.

## Timing
- Reset values: `rd_ack`=0, `wr_en`=0, `wr_data`=0, `leds`=0, `busy`=0, `err_unknown`=0, `err_overrun`=0; `inv_reg`, vector, `vec_ptr`, `avail_q`, `pending` = 0; state IDLE.
- Reset mid-sequence (VEC_RX, SEND, GAP): abort immediately, no further `wr_en`, partial vector writes kept until reset clears them.
- Edge at cycle N -> `rd_ack` high N+1; IDLE->EXEC N+1; register update visible N+3.
- Read command with `wr_buffer_free`=1 constant: `wr_en` at N+3.
- RD_VEC: `wr_en` pulses spaced ≥2 cycles; exactly 4 pulses.
- `rd_ack` and `wr_en` never high two consecutive cycles.

## Test plan
- Reset, then WR_LEDS 0x04_00_00_05 -> `rd_ack` one pulse, `leds`=0x0005 three cycles after edge; RD_LEDS -> one `wr_en`, `wr_data`=0x05000005.
- WR_INVERTED 0x02_00_12_34 then RD_INVERTED -> `wr_data`=0x0300EDCB.
- WR_VEC + payloads 0x111111, 0x222222, 0x333333, 0x444444; RD_VEC with `wr_buffer_free` toggling low for 5 cycles before word 2 -> 0x07111111..0x07444444 in order, exactly 4 `wr_en`, `busy` low afterwards.
- Opcode 0x09 -> `err_unknown`=1, no `wr_en`; INIT -> flags, `leds`, vector cleared.
- Two rising edges while SEND stalled (`wr_buffer_free`=0) -> two `rd_ack`, `err_overrun`=1, first buffered word executed after GAP.
- Reset asserted during RD_VEC after 2nd `wr_en` -> no more `wr_en`, all outputs at reset values next cycle.
